boilerplate_accum: RTL and testbench
====================================

# boilerplate_accum

Saturating running accumulator. Samples an unsigned PARAM1-bit input stream every clock and presents the PARAM2-bit saturating sum of all samples taken since the last reset. It is a generic datapath leaf: a producer drives `in` every cycle, and a consumer reads `out` as a registered value. There is no handshake; every clock edge outside reset consumes one sample.

## Interface
- PARAM1, default 10: width of `in` in bits. Must be ≥ 1.
- PARAM2, default 20: width of `out` and of the accumulator in bits. Must be ≥ PARAM1. Any other combination is an elaboration-time error.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- in  input  PARAM1  unsigned sample, captured on every rising edge of `clk` while `reset` is low.
- out  output  PARAM2  unsigned registered accumulator value.

## Operation
- State:
  - input register `s` (PARAM1 bits);
  - accumulator `acc` (PARAM2 bits);
  - `out` = `acc`, with no combinational path from `in`.
- Each rising edge with `reset` low:
  - `s` ← `in`;
  - `acc` ← sat(`acc` + zero-extend(`s`)).
- Arithmetic:
  - all operands are unsigned;
  - the sum is computed at PARAM2+1 bits;
  - if the sum exceeds 2^PARAM2−1, the result is 2^PARAM2−1, otherwise it is the sum.
- Saturation is sticky by construction: inputs are non-negative, so once `acc` is all-ones it stays there until reset.
- An input of 0 leaves `acc` unchanged (hold).
- No wrap-around under any input sequence.
- PARAM1 == PARAM2 is legal; saturation applies identically.

## Timing
- Reset:
  - while `reset` is high, `s` = 0, `acc` = 0 and `out` = 0 regardless of `clk` or `in`;
  - assertion takes effect asynchronously, without waiting for a clock edge;
  - assertion mid-accumulation discards all history.
- Reset release:
  - the first rising edge with `reset` low captures `in` into `s`, while `acc` adds the cleared `s` (0);
  - `out` therefore stays 0 for that edge.
- Latency is 2 clock edges from input to output: a sample present on `in` at edge N is captured into `s` at N and is visible on `out` after edge N+1.
- Throughput is 1 sample per clock, with no bubbles or stalls.
- Reset deasserted close to a clock edge is the integrator's responsibility. The block requires synchronous deassertion with respect to `clk`.
- `out` changes only on a rising edge of `clk` or on assertion of `reset`.

## Test plan
- Reset hold: `reset`=1 for 3+ cycles with `in`=123 toggling -> `out`=0 throughout; `out` goes to 0 within the same timestep as reset assertion, with no clock edge.
- Latency/sum: release reset, then drive `in`=123 at edge 1, `in`=456 at edge 2, `in`=0 thereafter -> `out`=0 after edge 1, 123 after edge 2, 579 after edge 3, and 579 held for 10 further cycles.
- Continuous accumulation: hold `in`=456 for 5 edges after reset release -> `out` = 0, 456, 912, 1368, 1824 after edges 1–5.
- Saturation boundary (PARAM1=10, PARAM2=20): hold `in`=1023 -> after 1025 accumulated samples `out`=1048575 exactly (no overflow); further samples keep `out`=1048575; then `in`=0 keeps it at 1048575.
- Reset mid-operation: accumulate to 579, assert `reset` asynchronously between edges -> `out`=0 immediately; release and drive `in`=7 -> `out`=7 two edges later.
- Parameter check: instantiate with PARAM2 < PARAM1 -> elaboration fails.

Source files
------------

// File: rtl/boilerplate_accum.sv
// Saturating running accumulator: registers each unsigned sample, then adds it
// into a PARAM2-bit accumulator that clamps at all-ones instead of wrapping.
module boilerplate_accum #(
    parameter int PARAM1 = 10,
    parameter int PARAM2 = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PARAM1-1:0] in,
    output logic [PARAM2-1:0] out
);

    generate
        if (PARAM1 < 1 || PARAM2 < PARAM1) begin : g_bad_params
            $error("boilerplate_accum: need PARAM1 >= 1 and PARAM2 >= PARAM1");
        end
    endgenerate

    localparam int EXT_W = PARAM2 + 1 - PARAM1;

    logic [PARAM1-1:0] s_q;
    logic [PARAM1-1:0] s_d;
    logic [PARAM2-1:0] acc_q;
    logic [PARAM2-1:0] acc_d;
    logic [PARAM2:0]   sum;

    // The extra carry bit of the sum is the overflow flag; clamp when it is set.
    function automatic logic [PARAM2-1:0] sat(input logic [PARAM2:0] val);
        if (val[PARAM2]) begin
            return {PARAM2{1'b1}};
        end
        return val[PARAM2-1:0];
    endfunction

    always_comb begin
        s_d   = in;
        sum   = {1'b0, acc_q} + {{EXT_W{1'b0}}, s_q};
        acc_d = sat(sum);
    end

    // Stage 1 captures the sample, stage 2 folds it into the accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q   <= '0;
            acc_q <= '0;
        end else begin
            s_q   <= s_d;
            acc_q <= acc_d;
        end
    end

    assign out = acc_q;

endmodule

// File: tb/tb_boilerplate_accum.sv
// Directed bench for boilerplate_accum at PARAM1=10, PARAM2=20.
module tb_boilerplate_accum;

    localparam int P1 = 10;
    localparam int P2 = 20;
    localparam logic [P2-1:0] SAT = 20'd1048575;

    logic          clk;
    logic          reset;
    logic [P1-1:0] in;
    logic [P2-1:0] out;

    int checks = 0;
    int errors = 0;

    boilerplate_accum #(.PARAM1(P1), .PARAM2(P2)) dut (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [P2-1:0] exp);
        checks++;
        assert (out === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, out, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse spanning one clock edge, released 1 unit after an edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        edge1();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in    = 10'd123;
        #1;
        chk("reset_t0", 20'd0);

        // Reset hold with toggling input
        for (int i = 0; i < 4; i++) begin
            in = (i % 2 == 0) ? 10'd123 : 10'd0;
            edge1();
            chk("reset_hold", 20'd0);
        end

        // Latency and sum
        reset = 1'b0;
        in    = 10'd123;
        edge1();
        chk("lat_e1", 20'd0);
        in = 10'd456;
        edge1();
        chk("lat_e2", 20'd123);
        in = 10'd0;
        edge1();
        chk("lat_e3", 20'd579);
        for (int i = 0; i < 10; i++) begin
            edge1();
            chk("lat_hold", 20'd579);
        end

        // No combinational path from in to out
        in = 10'd999;
        #2;
        chk("no_comb", 20'd579);
        in = 10'd0;

        // Asynchronous reset mid-operation, then restart with 7
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst", 20'd0);
        edge1();
        chk("async_rst_hold", 20'd0);
        reset = 1'b0;
        in    = 10'd7;
        edge1();
        chk("restart_e1", 20'd0);
        in = 10'd0;
        edge1();
        chk("restart_e2", 20'd7);

        // Continuous accumulation
        do_reset();
        in = 10'd456;
        edge1(); chk("cont_e1", 20'd0);
        edge1(); chk("cont_e2", 20'd456);
        edge1(); chk("cont_e3", 20'd912);
        edge1(); chk("cont_e4", 20'd1368);
        edge1(); chk("cont_e5", 20'd1824);

        // Saturation boundary: 1023 * 1025 == 2^20 - 1 exactly
        do_reset();
        in = 10'd1023;
        for (int i = 1; i <= 1024; i++) edge1();
        chk("sat_pre_1023", 20'd1046529);
        edge1();
        chk("sat_pre_1024", 20'd1047552);
        edge1();
        chk("sat_exact", SAT);
        for (int i = 0; i < 5; i++) begin
            edge1();
            chk("sat_sticky", SAT);
        end
        in = 10'd0;
        for (int i = 0; i < 4; i++) begin
            edge1();
            chk("sat_zero_hold", SAT);
        end

        // Overshoot past the limit clamps rather than wraps
        do_reset();
        in = 10'd1023;
        for (int i = 0; i < 1030; i++) edge1();
        in = 10'd1;
        edge1();
        edge1();
        chk("sat_no_wrap", SAT);

        // Reset clears a saturated accumulator
        #2;
        reset = 1'b1;
        #1;
        chk("sat_reset", 20'd0);
        edge1();
        reset = 1'b0;
        in = 10'd5;
        edge1();
        chk("post_sat_e1", 20'd0);
        edge1();
        chk("post_sat_e2", 20'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
